// File: rtl/bm_memory_seq_pkg.sv
// Shared definitions for the memory BIST sequencer: state encoding and default geometry.
package bm_memory_seq_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_ADDR_WIDTH = 2;
    localparam int WORD_COUNT     = 2 ** DEF_ADDR_WIDTH;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WRITE = 3'd1,
        READ  = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } state_t;

endpackage

// File: rtl/bm_memory_check_stage.sv
// Compare pipeline: aligns each issued read with the memory's registered output
// and accumulates the mismatch count and the first failing address.
module bm_memory_check_stage
    import bm_memory_seq_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  issue_valid,
    input  logic [ADDR_WIDTH-1:0] issue_addr,
    input  logic [DATA_WIDTH-1:0] issue_exp,
    input  logic [DATA_WIDTH-1:0] mem_value_out,
    output logic [ADDR_WIDTH:0]   error_count,
    output logic [ADDR_WIDTH-1:0] fail_address
);

    logic                  chk_valid_q, chk_valid_d;
    logic [ADDR_WIDTH-1:0] chk_addr_q, chk_addr_d;
    logic [DATA_WIDTH-1:0] chk_exp_q, chk_exp_d;
    logic [ADDR_WIDTH:0]   err_q, err_d;
    logic [ADDR_WIDTH-1:0] fail_addr_q, fail_addr_d;
    logic                  seen_fail_q, seen_fail_d;
    logic                  mismatch;

    assign mismatch     = chk_valid_q && (mem_value_out != chk_exp_q);
    assign error_count  = err_q;
    assign fail_address = fail_addr_q;

    always_comb begin
        chk_valid_d = issue_valid;
        chk_addr_d  = issue_valid ? issue_addr : '0;
        chk_exp_d   = issue_valid ? issue_exp : '0;
        err_d       = err_q;
        fail_addr_d = fail_addr_q;
        seen_fail_d = seen_fail_q;
        if (clear) begin
            err_d       = '0;
            fail_addr_d = '0;
            seen_fail_d = 1'b0;
        end else if (mismatch) begin
            err_d = err_q + (ADDR_WIDTH + 1)'(1);
            // Only the earliest failing address is kept
            if (!seen_fail_q) begin
                fail_addr_d = chk_addr_q;
                seen_fail_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            chk_valid_q <= 1'b0;
            chk_addr_q  <= '0;
            chk_exp_q   <= '0;
            err_q       <= '0;
            fail_addr_q <= '0;
            seen_fail_q <= 1'b0;
        end else begin
            chk_valid_q <= chk_valid_d;
            chk_addr_q  <= chk_addr_d;
            chk_exp_q   <= chk_exp_d;
            err_q       <= err_d;
            fail_addr_q <= fail_addr_d;
            seen_fail_q <= seen_fail_d;
        end
    end

endmodule

// File: rtl/bm_memory_sequencer.sv
// BIST initiator: writes seed+addr into every word, reads all words back through
// the check stage, and reports pass/fail for the run.
module bm_memory_sequencer
    import bm_memory_seq_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] seed,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_address_in,
    output logic [DATA_WIDTH-1:0] mem_value_in,
    output logic [ADDR_WIDTH-1:0] mem_address_out,
    input  logic [DATA_WIDTH-1:0] mem_value_out,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [ADDR_WIDTH:0]   error_count,
    output logic [ADDR_WIDTH-1:0] fail_address
);

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] seed_q, seed_d;
    logic                  pass_q, pass_d;
    logic                  clear;
    logic                  issue_valid;
    logic [DATA_WIDTH-1:0] pattern;
    logic                  cnt_last;

    // Expected word for the current counter value, shared by write and read phases
    assign pattern  = seed_q + DATA_WIDTH'(cnt_q);
    assign cnt_last = (cnt_q == '1);

    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        seed_d          = seed_q;
        pass_d          = pass_q;
        clear           = 1'b0;
        issue_valid     = 1'b0;
        mem_we          = 1'b0;
        mem_address_in  = '0;
        mem_value_in    = '0;
        mem_address_out = '0;
        done            = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = WRITE;
                    cnt_d   = '0;
                    seed_d  = seed;
                    pass_d  = 1'b0;
                    clear   = 1'b1;
                end
            end
            WRITE: begin
                mem_we         = 1'b1;
                mem_address_in = cnt_q;
                mem_value_in   = pattern;
                cnt_d          = cnt_q + ADDR_WIDTH'(1);
                if (cnt_last) begin
                    state_d = READ;
                    cnt_d   = '0;
                end
            end
            READ: begin
                mem_address_out = cnt_q;
                issue_valid     = 1'b1;
                cnt_d           = cnt_q + ADDR_WIDTH'(1);
                if (cnt_last) begin
                    state_d = DRAIN;
                    cnt_d   = '0;
                end
            end
            DRAIN: begin
                state_d = DONE;
            end
            DONE: begin
                done    = 1'b1;
                pass_d  = (error_count == '0);
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            seed_q  <= '0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            seed_q  <= seed_d;
            pass_q  <= pass_d;
        end
    end

    assign busy = (state_q != IDLE);
    assign pass = pass_q;

    bm_memory_check_stage #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_check (
        .clock        (clock),
        .reset        (reset),
        .clear        (clear),
        .issue_valid  (issue_valid),
        .issue_addr   (cnt_q),
        .issue_exp    (pattern),
        .mem_value_out(mem_value_out),
        .error_count  (error_count),
        .fail_address (fail_address)
    );

endmodule

// File: tb/tb_bm_memory_sequencer.sv
// Bench for bm_memory_sequencer: a 4x8 registered-read memory with an optional
// stuck-at mask, table-driven and random runs, and start/reset corner sequences.
module tb_bm_memory_sequencer;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [7:0] seed  = 8'h00;
    logic       mem_we;
    logic [1:0] mem_address_in;
    logic [7:0] mem_value_in;
    logic [1:0] mem_address_out;
    logic [7:0] mem_value_out;
    logic       busy;
    logic       done;
    logic       pass;
    logic [2:0] error_count;
    logic [1:0] fail_address;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] mem [4];
    logic [7:0] mask_r = 8'hFF;

    always #5 clock = ~clock;

    // Memory model: bits cleared in mask_r are stuck at 0 on write
    initial begin
        for (int i = 0; i < 4; i++) mem[i] = 8'h00;
        mem_value_out = 8'h00;
    end
    always @(posedge clock) begin
        if (mem_we) mem[mem_address_in] <= mem_value_in & mask_r;
        mem_value_out <= mem[mem_address_out];
    end

    bm_memory_sequencer dut (
        .clock          (clock),
        .reset          (reset),
        .start          (start),
        .seed           (seed),
        .mem_we         (mem_we),
        .mem_address_in (mem_address_in),
        .mem_value_in   (mem_value_in),
        .mem_address_out(mem_address_out),
        .mem_value_out  (mem_value_out),
        .busy           (busy),
        .done           (done),
        .pass           (pass),
        .error_count    (error_count),
        .fail_address   (fail_address)
    );

    typedef struct {
        logic [7:0] seed;
        logic [7:0] mask;
        bit         exp_pass;
        int         exp_err;
        int         exp_fail;
    } vec_t;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: which words come back wrong through the stuck mask
    function automatic void model(input logic [7:0] s, input logic [7:0] m,
                                  output int errs, output int first);
        logic [7:0] w;
        errs  = 0;
        first = 0;
        for (int i = 0; i < 4; i++) begin
            w = s + 8'(i);
            if ((w & m) != w) begin
                if (errs == 0) first = i;
                errs++;
            end
        end
    endfunction

    task automatic wait_idle();
        for (int i = 0; i < 30 && busy; i++) step();
        chk("idle_wait", {31'd0, busy}, 32'd0);
    endtask

    // pat[k] is the start level driven during cycle k (1..11) of the run
    task automatic run(input logic [7:0] s, input logic [7:0] m, input logic [11:0] pat,
                       input bit chained, input string tag);
        int  e, f;
        bit  w;
        model(s, m, e, f);
        if (!chained) wait_idle();
        mask_r = m;
        seed   = s;
        start  = 1'b1;
        step();
        for (int k = 1; k <= 10; k++) begin
            start = pat[k];
            w = (k >= 1 && k <= 4);
            chk($sformatf("%s c%0d mem_we", tag, k), {31'd0, mem_we}, {31'd0, w});
            chk($sformatf("%s c%0d addr_in", tag, k), 32'(mem_address_in), w ? 32'(k - 1) : 32'd0);
            chk($sformatf("%s c%0d value_in", tag, k), 32'(mem_value_in),
                w ? 32'(8'(s + 8'(k - 1))) : 32'd0);
            chk($sformatf("%s c%0d addr_out", tag, k), 32'(mem_address_out),
                (k >= 5 && k <= 8) ? 32'(k - 5) : 32'd0);
            chk($sformatf("%s c%0d busy", tag, k), {31'd0, busy}, 32'd1);
            chk($sformatf("%s c%0d done", tag, k), {31'd0, done}, (k == 10) ? 32'd1 : 32'd0);
            if (k == 1) begin
                chk($sformatf("%s c1 err_clr", tag), 32'(error_count), 32'd0);
                chk($sformatf("%s c1 fail_clr", tag), 32'(fail_address), 32'd0);
                chk($sformatf("%s c1 pass_clr", tag), {31'd0, pass}, 32'd0);
            end
            step();
        end
        start = pat[11];
        chk($sformatf("%s pass", tag), {31'd0, pass}, (e == 0) ? 32'd1 : 32'd0);
        chk($sformatf("%s error_count", tag), 32'(error_count), 32'(e));
        chk($sformatf("%s fail_address", tag), 32'(fail_address), 32'(f));
        chk($sformatf("%s c11 busy", tag), {31'd0, busy}, 32'd0);
        chk($sformatf("%s c11 done", tag), {31'd0, done}, 32'd0);
        $display("run %s seed=%02h mask=%02h pass=%0b errs=%0d fail=%0d", tag, s, m,
                 pass, error_count, fail_address);
    endtask

    vec_t vecs [5];
    logic [7:0] masks [4];

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, got hang expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0] = '{seed: 8'h10, mask: 8'hFF, exp_pass: 1'b1, exp_err: 0, exp_fail: 0};
        vecs[1] = '{seed: 8'hFE, mask: 8'hFF, exp_pass: 1'b1, exp_err: 0, exp_fail: 0};
        vecs[2] = '{seed: 8'h10, mask: 8'hFE, exp_pass: 1'b0, exp_err: 2, exp_fail: 1};
        vecs[3] = '{seed: 8'h00, mask: 8'hFE, exp_pass: 1'b0, exp_err: 2, exp_fail: 1};
        vecs[4] = '{seed: 8'h20, mask: 8'hFF, exp_pass: 1'b1, exp_err: 0, exp_fail: 0};
        masks[0] = 8'hFF; masks[1] = 8'hFE; masks[2] = 8'h7F; masks[3] = 8'hEF;

        step(); step();
        reset = 1'b0;
        chk("rst busy", {31'd0, busy}, 32'd0);
        chk("rst done", {31'd0, done}, 32'd0);
        chk("rst pass", {31'd0, pass}, 32'd0);
        chk("rst mem_we", {31'd0, mem_we}, 32'd0);
        chk("rst addr_in", 32'(mem_address_in), 32'd0);
        chk("rst value_in", 32'(mem_value_in), 32'd0);
        chk("rst addr_out", 32'(mem_address_out), 32'd0);
        chk("rst error_count", 32'(error_count), 32'd0);
        chk("rst fail_address", 32'(fail_address), 32'd0);
        step();

        // Table: fixed vectors, including the back-to-back faulty/clean pair
        for (int i = 0; i < 5; i++) begin
            run(vecs[i].seed, vecs[i].mask, 12'h000, 1'b0, $sformatf("vec%0d", i));
            chk($sformatf("vec%0d tbl_pass", i), {31'd0, pass}, {31'd0, vecs[i].exp_pass});
            chk($sformatf("vec%0d tbl_err", i), 32'(error_count), 32'(vecs[i].exp_err));
            chk($sformatf("vec%0d tbl_fail", i), 32'(fail_address), 32'(vecs[i].exp_fail));
        end

        // Start pulsed in cycle 4 and in the DONE cycle: neither is accepted
        run(8'h33, 8'hFF, 12'b0100_0001_0000, 1'b0, "ignore");
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("ignore idle%0d busy", i), {31'd0, busy}, 32'd0);
            chk($sformatf("ignore idle%0d done", i), {31'd0, done}, 32'd0);
            step();
        end

        // Start held high: the second run is accepted in the first IDLE cycle
        run(8'h44, 8'hFF, 12'hFFE, 1'b0, "hold1");
        run(8'h80, 8'h7F, 12'h000, 1'b1, "hold2");
        step();

        // Reset in cycle 6 aborts the run with no result
        wait_idle();
        mask_r = 8'hFE;
        seed   = 8'h10;
        start  = 1'b1;
        step();
        start = 1'b0;
        for (int k = 1; k < 6; k++) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("abort busy", {31'd0, busy}, 32'd0);
        chk("abort mem_we", {31'd0, mem_we}, 32'd0);
        chk("abort pass", {31'd0, pass}, 32'd0);
        chk("abort error_count", 32'(error_count), 32'd0);
        chk("abort fail_address", 32'(fail_address), 32'd0);
        begin
            bit saw_done = 1'b0;
            bit saw_busy = 1'b0;
            for (int k = 0; k < 12; k++) begin
                if (done) saw_done = 1'b1;
                if (busy) saw_busy = 1'b1;
                step();
            end
            chk("abort no_done", {31'd0, saw_done}, 32'd0);
            chk("abort no_busy", {31'd0, saw_busy}, 32'd0);
        end
        $display("run abort seed=10 mask=FE reset in cycle 6");

        // Random runs against the reference model
        for (int r = 0; r < 12; r++) begin
            logic [7:0] rs, rm;
            rs = 8'($urandom);
            rm = (r % 5 == 4) ? 8'($urandom) : masks[$urandom_range(0, 3)];
            run(rs, rm, 12'h000, 1'b0, $sformatf("rnd%0d", r));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
